// File: rtl/tron_pkg.sv
// Shared constants, types and the cell-address packing used by every trail-memory
// reader and writer.
package tron_pkg;

  localparam int GRID_W    = 160;
  localparam int GRID_H    = 120;
  localparam int ADDR_W    = 15;
  localparam int CX_W      = 8;
  localparam int CY_W      = 7;
  localparam int CLR_CNT_W = 16;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_SWEEP,
    CLR_DONE
  } clr_state_e;

  // Per-pixel tag carried down the render pipeline alongside the BRAM read.
  typedef struct packed {
    logic            vld;
    logic            von;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
  } pix_tag_t;

  // Colours as {r,g,b} full-scale enables; the top widens each bit to a DAC channel.
  typedef logic [2:0] rgb_mask_t;
  localparam rgb_mask_t COL_BLACK   = 3'b000;
  localparam rgb_mask_t COL_WHITE   = 3'b111;
  localparam rgb_mask_t COL_YELLOW  = 3'b110;
  localparam rgb_mask_t COL_MAGENTA = 3'b101;
  localparam rgb_mask_t COL_CYAN    = 3'b011;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [CX_W-1:0] cx,
                                                  input logic [CY_W-1:0] cy);
    return {cy, cx};
  endfunction

endpackage

// File: rtl/tron_mem_clear.sv
// Full-memory clear sweep: owns the BRAM write port and zeroes all 2^15 addresses
// after reset (optionally) or on a clear request.
module tron_mem_clear
  import tron_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] wraddress,
  output logic              data,
  output logic              wren,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam logic [CLR_CNT_W-1:0] LAST_ADDR = CLR_CNT_W'((1 << ADDR_W) - 1);

  clr_state_e           state_q, state_d;
  logic [CLR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 armed_q;  // holds off the first write until one clk after release

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= CLEAR_ON_RESET ? CLR_SWEEP : CLR_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wren       = 1'b0;
    clear_done = 1'b0;
    unique case (state_q)
      CLR_IDLE: begin
        if (clear_req) begin
          state_d = CLR_SWEEP;
          cnt_d   = '0;
        end
      end
      CLR_SWEEP: begin
        if (armed_q) begin
          wren  = 1'b1;
          cnt_d = cnt_q + CLR_CNT_W'(1);
          if (cnt_q == LAST_ADDR) state_d = CLR_DONE;
        end
      end
      CLR_DONE: begin
        clear_done = 1'b1;
        state_d    = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign wraddress  = wren ? cnt_q[ADDR_W-1:0] : '0;
  assign data       = 1'b0;
  assign clear_busy = (state_q == CLR_SWEEP);

endmodule

// File: rtl/tron_trail_renderer.sv
// Raster-order reader of the 1-bit trail BRAM: three-stage pixel pipeline producing
// DAC colour, plus the clear sweep that owns the write port.
module tron_trail_renderer #(
  parameter int COLOR_W        = 10,
  parameter int GRID_W         = tron_pkg::GRID_W,
  parameter int GRID_H         = tron_pkg::GRID_H,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        pix_en,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic                        video_on,
  input  logic [7:0]                  head1_x,
  input  logic [7:0]                  head2_x,
  input  logic [6:0]                  head1_y,
  input  logic [6:0]                  head2_y,
  input  logic                        clear_req,
  output logic [tron_pkg::ADDR_W-1:0] rdaddress,
  input  logic                        q,
  output logic [tron_pkg::ADDR_W-1:0] wraddress,
  output logic                        data,
  output logic                        wren,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic [COLOR_W-1:0]          vga_r,
  output logic [COLOR_W-1:0]          vga_g,
  output logic [COLOR_W-1:0]          vga_b
);

  localparam logic [7:0] CX_LAST = 8'(GRID_W - 1);
  localparam logic [6:0] CY_LAST = 7'(GRID_H - 1);

  tron_pkg::pix_tag_t  s0_q, s1_q;
  logic                bit1_q;
  tron_pkg::rgb_mask_t col_q, col_d;
  logic                border, is_head1, is_head2;
  logic                unused_px_bits;

  assign unused_px_bits = ^{pixel_x[1:0], pixel_y[9], pixel_y[1:0]};

  // S0 drives the read address; q for it is captured at the next strobe (S1).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s0_q   <= '0;
      s1_q   <= '0;
      bit1_q <= 1'b0;
      col_q  <= tron_pkg::COL_BLACK;
    end else if (pix_en) begin
      s0_q   <= '{vld: 1'b1, von: video_on, cx: pixel_x[9:2], cy: pixel_y[8:2]};
      s1_q   <= s0_q;
      bit1_q <= q;
      col_q  <= col_d;
    end
  end

  assign rdaddress = tron_pkg::cell_addr(s0_q.cx, s0_q.cy);

  assign border   = (s1_q.cx == 8'd0) || (s1_q.cx == CX_LAST) ||
                    (s1_q.cy == 7'd0) || (s1_q.cy == CY_LAST);
  assign is_head1 = (s1_q.cx == head1_x) && (s1_q.cy == head1_y);
  assign is_head2 = (s1_q.cx == head2_x) && (s1_q.cy == head2_y);

  always_comb begin
    col_d = tron_pkg::COL_BLACK;
    if (!(s1_q.vld && s1_q.von)) col_d = tron_pkg::COL_BLACK;
    else if (border)             col_d = tron_pkg::COL_WHITE;
    else if (is_head1)           col_d = tron_pkg::COL_YELLOW;
    else if (is_head2)           col_d = tron_pkg::COL_MAGENTA;
    else if (bit1_q)             col_d = tron_pkg::COL_CYAN;
  end

  assign vga_r = {COLOR_W{col_q[2]}};
  assign vga_g = {COLOR_W{col_q[1]}};
  assign vga_b = {COLOR_W{col_q[0]}};

  // NOTE: the BRAM itself has no reset; its contents are zeroed by the clear sweep.
  tron_mem_clear #(
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_mem_clear (
    .clk       (clk),
    .resetn    (resetn),
    .clear_req (clear_req),
    .wraddress (wraddress),
    .data      (data),
    .wren      (wren),
    .clear_busy(clear_busy),
    .clear_done(clear_done)
  );

endmodule

// File: doc/tron_trail_renderer.md
# tron_trail_renderer

Read-side companion to the trail-memory writer. It scans the shared 1-bit trail BRAM (`tron_memory`) in VGA raster order through the read port and produces per-pixel RGB for the DAC. It also owns the write port during a full-memory clear sweep at reset or game start. It sits between the VGA sync generator and the DE2 video DAC, alongside the per-player collision/write logic.

## Interface
Parameters:
- `COLOR_W`, 10: bits per colour channel (ADV7123).
- `GRID_W`, 160: cells per row (640 px / 4).
- `GRID_H`, 120: cells per column (480 px / 4).
- `CLEAR_ON_RESET`, 1: when 1, start a clear sweep automatically on reset release.

Ports:
- `clk`  in  1  50 MHz system clock.
- `resetn`  in  1  synchronous, active-low reset.
- `pix_en`  in  1  one-`clk` strobe per 25 MHz pixel.
- `pixel_x`, `pixel_y`  in  10 each  raster coordinates from the sync generator.
- `video_on`  in  1  active-area flag, aligned with `pixel_x`/`pixel_y`.
- `head1_x`, `head2_x`  in  8 each  player head cell X.
- `head1_y`, `head2_y`  in  7 each  player head cell Y.
- `clear_req`  in  1  single-cycle pulse requesting a full clear.
- `rdaddress`  out  15  BRAM read address.
- `q`  in  1  BRAM read data; valid 1 `clk` after `rdaddress`.
- `wraddress`  out  15  BRAM write address; driven only during clear.
- `data`  out  1  BRAM write data; always 0.
- `wren`  out  1  BRAM write enable.
- `clear_busy`  out  1  high while the sweep owns the write port.
- `clear_done`  out  1  one-`clk` pulse after the last write.
- `vga_r`, `vga_g`, `vga_b`  out  `COLOR_W` each  pixel colour.

## Operation
- Cell mapping: `cx = pixel_x[9:2]`, `cy = pixel_y[8:2]`; address = {`cy`[6:0], `cx`[7:0]} (15 bits). Every writer in the design uses this same packing.
- Render pipeline, three stages, each advancing only on `pix_en`:
  - S0: register `cx`, `cy`, `video_on`; drive `rdaddress`.
  - S1: `q` valid; carry `cx`, `cy`, `video_on`.
  - S2: register colour.
- Colour priority, first match wins:
  1. `!video_on` → 0.
  2. Border cell (`cx==0`, `cx==GRID_W-1`, `cy==0`, or `cy==GRID_H-1`) → white (all channels full scale).
  3. Head 1 → yellow (R, G full; B 0).
  4. Head 2 → magenta (R, B full; G 0).
  5. `q==1` → cyan (G, B full; R 0).
  6. Otherwise black.
- Clear FSM:
  - IDLE: on `clear_req`, go to CLEAR with counter 0.
  - CLEAR: `wren=1`, `data=0`, `wraddress=counter`; counter increments every `clk` from 0 to 32767 (full 2^15 space, including unused addresses). After address 32767, go to DONE.
  - DONE: `wren=0`, `clear_done=1` for one cycle, then IDLE.
- `clear_busy` = (state==CLEAR). Game writers must not assert a write while it is high.
- `clear_req` in CLEAR or DONE is ignored; the sweep does not restart.
- The read pipeline keeps running during a clear; stale or partially cleared pixels are acceptable.

## Timing
- Reset values:
  - `rdaddress=0`, `wraddress=0`, `data=0`, `wren=0`, `clear_done=0`, RGB=0, pipeline valid bits 0.
  - `clear_busy=CLEAR_ON_RESET`; the FSM enters CLEAR with counter 0 on the first cycle after `resetn` rises (IDLE if the parameter is 0).
- Render latency: exactly 2 `pix_en` strobes from coordinate sample to RGB update. The sync generator delays HS/VS by 2 pixels to match.
- Clear duration: 32768 `clk` with `wren` high (≈655 µs); `clear_done` on the following `clk`.
- Reset mid-sweep: `wren` drops in the reset cycle. Memory is left partially cleared. With `CLEAR_ON_RESET=1` the sweep restarts from 0.
- `clear_req` coinciding with reset is dropped.
- Counter width is 16 bits so the terminal compare does not wrap.

## Structure
- Shared package `tron_pkg`:
  - constants `GRID_W`, `GRID_H`, `ADDR_W`=15;
  - cell-to-address packing function;
  - colour constants.
- One sub-module: `tron_mem_clear`, containing the clear FSM and counter. It drives `wraddress`, `wren`, `data`, `clear_busy`, `clear_done`.
- Top level holds the render pipeline and colour mux.

## Test plan
- Reset release with `CLEAR_ON_RESET=1` → `wren` high for exactly 32768 cycles with addresses 0..32767 in order; `clear_done` pulses once; `clear_busy` low after.
- Preload BRAM bit at {`cy`=50, `cx`=80}; raster `pixel_x`=320..323, `pixel_y`=200 → cyan (0,1023,1023) two `pix_en` later; neighbours black.
- `head1`=(80,50) with the same bit set → yellow wins over cyan.
- `pixel_x`=0 with `video_on`=1 → white; `video_on`=0 at any cell → RGB 0.
- `clear_req` at sweep cycle 1000 → no restart; total write count remains 32768.
- `resetn` low at sweep cycle 5000 → `wren`=0 next cycle; after release the sweep restarts at address 0.
